drbg_ctrl: RTL

- Command sequencer for the CTR_DRBG (AES-256, no derivation function, seedlen 384).
- Holds the working state (key, V, reseed counter).
- Executes INSTANTIATE / RESEED / GENERATE by driving a shared external AES-256 encrypt core over a start/done handshake.
- Streams 128-bit random blocks out over valid/ready. Sits between the host command interface and the AES core.

---
 rtl/drbg_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/drbg_ctrl.sv
// -----------------------------------------------------------------------------
// drbg_ctrl -- CTR_DRBG command sequencer (AES-256, no derivation function,
// seedlen 384).
//
// Keeps the DRBG working state (key, V, reseed counter). It runs INSTANTIATE,
// RESEED and GENERATE by driving a shared external AES-256 encrypt core over a
// start/done handshake, and it streams 128-bit random blocks out over
// valid/ready.
//
// Configuration macro: DRBG_ADDIN_EN
//   defined   : GENERATE uses cmd_data_i as additional input. A nonzero value
//               is folded in by an UPDATE before the blocks are produced, and
//               it also feeds the UPDATE that follows generation.
//   undefined : GENERATE ignores cmd_data_i, and the UPDATE that follows
//               generation always uses zero.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o command handshake (ready only in IDLE)
//   cmd_op_i                00 INSTANTIATE, 01 RESEED, 10 GENERATE, 11 reserved
//   cmd_data_i              384-bit provided data / additional input
//   cmd_nblk_i              number of 128-bit blocks for GENERATE
//   aes_start_o             one-cycle encrypt request
//   aes_key_o, aes_pt_o     current key and V (plaintext), held during a call
//   aes_done_i, aes_ct_i    completion strobe and ciphertext
//   out_valid_o/out_ready_i random block handshake
//   out_data_o, out_last_o  random block, final block of the command
//   busy_o                  sequencer not idle
//   instantiated_o          working state is valid
//   reseed_req_o            GENERATE refused because the reseed interval ran out
//   err_o                   one-cycle pulse for a rejected command
//   reseed_counter_o        current reseed counter
// -----------------------------------------------------------------------------
module drbg_ctrl #(
    parameter logic [31:0] RESEED_INTERVAL = 32'h0001_0000,
    parameter int unsigned NBLK_W          = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [383:0]      cmd_data_i,
    input  logic [NBLK_W-1:0] cmd_nblk_i,
    output logic              aes_start_o,
    output logic [255:0]      aes_key_o,
    output logic [127:0]      aes_pt_o,
    input  logic              aes_done_i,
    input  logic [127:0]      aes_ct_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [127:0]      out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              instantiated_o,
    output logic              reseed_req_o,
    output logic              err_o,
    output logic [31:0]       reseed_counter_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_UPD_REQ, ST_UPD_WAIT, ST_UPD_FIN, ST_GEN_REQ, ST_GEN_WAIT, ST_GEN_OUT
    } state_e;

    // Which command an UPDATE in flight belongs to, so UPD_FIN knows where to go.
    typedef enum logic [1:0] {
        PH_SEED, PH_GEN_PRE, PH_GEN_POST
    } phase_e;

    state_e              state_q, state_d;
    phase_e              phase_q, phase_d;
    logic [255:0]        key_q, key_d;
    logic [127:0]        v_q, v_d;
    logic [383:0]        temp_q, temp_d;
    logic [383:0]        upd_data_q, upd_data_d;
    logic [NBLK_W-1:0]   nblk_q, nblk_d;
    logic [NBLK_W-1:0]   blk_q, blk_d;
    logic [1:0]          call_q, call_d;
    logic [31:0]         rc_q, rc_d;
    logic                inst_q, inst_d;
    logic                rreq_q, rreq_d;
    logic                err_q, err_d;
    logic                start_q, start_d;
    logic                ovalid_q, ovalid_d;
    logic [127:0]        odata_q, odata_d;
    logic                olast_q, olast_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic [383:0]        mixed_s;

    // Result of an UPDATE: the three keystream blocks folded with the provided data.
    assign mixed_s = temp_q ^ upd_data_q;

    // State and output registers; reset clears everything, including instantiated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_SEED;
            key_q      <= 256'd0;
            v_q        <= 128'd0;
            temp_q     <= 384'd0;
            upd_data_q <= 384'd0;
            nblk_q     <= {NBLK_W{1'b0}};
            blk_q      <= {NBLK_W{1'b0}};
            call_q     <= 2'd0;
            rc_q       <= 32'd0;
            inst_q     <= 1'b0;
            rreq_q     <= 1'b0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            ovalid_q   <= 1'b0;
            odata_q    <= 128'd0;
            olast_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            key_q      <= key_d;
            v_q        <= v_d;
            temp_q     <= temp_d;
            upd_data_q <= upd_data_d;
            nblk_q     <= nblk_d;
            blk_q      <= blk_d;
            call_q     <= call_d;
            rc_q       <= rc_d;
            inst_q     <= inst_d;
            rreq_q     <= rreq_d;
            err_q      <= err_d;
            start_q    <= start_d;
            ovalid_q   <= ovalid_d;
            odata_q    <= odata_d;
            olast_q    <= olast_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Command decode, UPDATE/GENERATE sequencing and next-state of all registers.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        key_d      = key_q;
        v_d        = v_q;
        temp_d     = temp_q;
        upd_data_d = upd_data_q;
        nblk_d     = nblk_q;
        blk_d      = blk_q;
        call_d     = call_q;
        rc_d       = rc_q;
        inst_d     = inst_q;
        rreq_d     = rreq_q;
        err_d      = 1'b0;
        start_d    = 1'b0;
        ovalid_d   = ovalid_q;
        odata_d    = odata_q;
        olast_d    = olast_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    nblk_d = cmd_nblk_i;
                    call_d = 2'd0;
                    case (cmd_op_i)
                        2'b00: begin
                            key_d      = 256'd0;
                            v_d        = 128'd0;
                            upd_data_d = cmd_data_i;
                            phase_d    = PH_SEED;
                            state_d    = ST_UPD_REQ;
                        end
                        2'b01: begin
                            if (inst_q) begin
                                upd_data_d = cmd_data_i;
                                phase_d    = PH_SEED;
                                state_d    = ST_UPD_REQ;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        2'b10: begin
                            if (rc_q > RESEED_INTERVAL) begin
                                err_d  = 1'b1;
                                rreq_d = 1'b1;
                            end else if (!inst_q || (cmd_nblk_i == {NBLK_W{1'b0}})) begin
                                err_d = 1'b1;
                            end else begin
                                blk_d = NBLK_W'(1);
`ifdef DRBG_ADDIN_EN
                                upd_data_d = cmd_data_i;
                                if (cmd_data_i != 384'd0) begin
                                    phase_d = PH_GEN_PRE;
                                    state_d = ST_UPD_REQ;
                                end else begin
                                    phase_d = PH_GEN_POST;
                                    state_d = ST_GEN_REQ;
                                end
`else
                                upd_data_d = 384'd0;
                                phase_d    = PH_GEN_POST;
                                state_d    = ST_GEN_REQ;
`endif
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UPD_REQ: begin
                v_d     = v_q + 128'd1;
                start_d = 1'b1;
                state_d = ST_UPD_WAIT;
            end
            ST_UPD_WAIT: begin
                if (aes_done_i) begin
                    // Keystream fills temp from the top: call 0 -> [383:256].
                    case (call_q)
                        2'd0:    temp_d[383:256] = aes_ct_i;
                        2'd1:    temp_d[255:128] = aes_ct_i;
                        default: temp_d[127:0]   = aes_ct_i;
                    endcase
                    if (call_q == 2'd2) begin
                        state_d = ST_UPD_FIN;
                    end else begin
                        call_d  = call_q + 2'd1;
                        state_d = ST_UPD_REQ;
                    end
                end else begin
                    state_d = ST_UPD_WAIT;
                end
            end
            ST_UPD_FIN: begin
                key_d = mixed_s[383:128];
                v_d   = mixed_s[127:0];
                case (phase_q)
                    PH_SEED: begin
                        rc_d    = 32'd1;
                        inst_d  = 1'b1;
                        rreq_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                    PH_GEN_PRE: begin
                        state_d = ST_GEN_REQ;
                    end
                    default: begin
                        rc_d    = (rc_q == 32'hFFFF_FFFF) ? rc_q : rc_q + 32'd1;
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_GEN_REQ: begin
                v_d     = v_q + 128'd1;
                start_d = 1'b1;
                state_d = ST_GEN_WAIT;
            end
            ST_GEN_WAIT: begin
                if (aes_done_i) begin
                    odata_d  = aes_ct_i;
                    ovalid_d = 1'b1;
                    olast_d  = (blk_q == nblk_q);
                    state_d  = ST_GEN_OUT;
                end else begin
                    state_d = ST_GEN_WAIT;
                end
            end
            ST_GEN_OUT: begin
                if (out_ready_i) begin
                    ovalid_d = 1'b0;
                    olast_d  = 1'b0;
                    if (olast_q) begin
                        call_d  = 2'd0;
                        phase_d = PH_GEN_POST;
                        state_d = ST_UPD_REQ;
                    end else begin
                        blk_d   = blk_q + NBLK_W'(1);
                        state_d = ST_GEN_REQ;
                    end
                end else begin
                    state_d = ST_GEN_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    assign cmd_ready_o      = ready_q;
    assign aes_start_o      = start_q;
    assign aes_key_o        = key_q;
    assign aes_pt_o         = v_q;
    assign out_valid_o      = ovalid_q;
    assign out_data_o       = odata_q;
    assign out_last_o       = olast_q;
    assign busy_o           = busy_q;
    assign instantiated_o   = inst_q;
    assign reseed_req_o     = rreq_q;
    assign err_o            = err_q;
    assign reseed_counter_o = rc_q;

endmodule
